// File: rtl/aes_sub_pkg.sv
// aes_sub_pkg: byte/state types, row-permutation index helpers and beat count shared by the SubBytes+ShiftRows datapath
package aes_sub_pkg;
  localparam int NUM_BYTES = 16;
  typedef logic [7:0] byte_t;
  typedef byte_t [NUM_BYTES-1:0] state_t;
  typedef enum logic [1:0] {PERM_ENC, PERM_DEC, PERM_BYP} perm_mode_t;
  function automatic logic [3:0] shift_idx(input logic [3:0] i);
    return i + {i[1:0], 2'b00};
  endfunction
  function automatic logic [3:0] inv_shift_idx(input logic [3:0] i);
    return i - {i[1:0], 2'b00};
  endfunction
  function automatic int beats(input int lanes);
    return NUM_BYTES / lanes;
  endfunction
endpackage

// File: rtl/aes_row_perm.sv
// aes_row_perm: combinational ShiftRows/InvShiftRows/identity mux; s = working state, mode = enc/dec/bypass, d = permuted state
module aes_row_perm
  import aes_sub_pkg::*;
(
  input  state_t     s,
  input  perm_mode_t mode,
  output state_t     d
);
  always_comb begin
    d = s;
    for (int i = 0; i < NUM_BYTES; i++)
      d[4'(i)] = mode == PERM_BYP ? s[4'(i)] :
                 mode == PERM_DEC ? s[inv_shift_idx(4'(i))] : s[shift_idx(4'(i))];
  end
endmodule

// File: rtl/subbytes_lanes.sv
// subbytes_lanes: beat-serial SubBytes over LANES external S-boxes then row permutation; start_i/decrypt_i/bypass_i/data_i request, ready_o/busy_o/data_o result, sbox_* lane interface
module subbytes_lanes
  import aes_sub_pkg::*;
#(
  parameter int LANES    = 1,
  parameter int SBOX_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic               decrypt_i,
  input  logic               bypass_i,
  input  logic [127:0]       data_i,
  output logic               ready_o,
  output logic               busy_o,
  output logic [127:0]       data_o,
  output logic [8*LANES-1:0] sbox_data_o,
  input  logic [8*LANES-1:0] sbox_data_i,
  output logic               sbox_decrypt_o
);
  localparam int BEATS = beats(LANES);
  localparam int LAST  = BEATS - 1 + SBOX_LAT;
  if (!(LANES inside {1, 2, 4, 8, 16})) begin : g_bad_lanes
    $error("subbytes_lanes: LANES must be 1, 2, 4, 8 or 16");
  end
  if (SBOX_LAT < 1 || SBOX_LAT > 3) begin : g_bad_lat
    $error("subbytes_lanes: SBOX_LAT must be 1..3");
  end
  typedef enum logic {IDLE, RUN} fsm_t;
  fsm_t       state, state_n;
  logic [4:0] cyc, cap;
  state_t     din, src, work, work_n, perm;
  logic [127:0] perm_flat;
  logic       dec_q, byp_q, accept, last;
  perm_mode_t mode;
  assign accept         = state == IDLE && start_i && !reset;
  assign last           = state == RUN && cyc == 5'(LAST);
  assign cap            = cyc - 5'(SBOX_LAT);
  assign busy_o         = state == RUN;
  assign sbox_decrypt_o = state == RUN ? dec_q : decrypt_i;
  assign mode           = byp_q ? PERM_BYP : dec_q ? PERM_DEC : PERM_ENC;
  assign state_n        = accept ? RUN : last ? IDLE : state;
  always_comb begin
    din       = '0;
    perm_flat = '0;
    for (int k = 0; k < NUM_BYTES; k++) begin
      din[4'(k)]              = data_i[127-8*k -: 8];
      perm_flat[127-8*k -: 8] = perm[4'(k)];
    end
  end
  // beat 0 comes straight from data_i on accept; later beats from the latched copy
  always_comb begin
    sbox_data_o = '0;
    for (int l = 0; l < LANES; l++)
      sbox_data_o[8*l +: 8] = accept ? din[4'(l)] :
                              (state == RUN && int'(cyc) < BEATS) ? src[4'(int'(cyc) * LANES + l)] : 8'h00;
  end
  // the final beat is merged here so data_o loads in the same edge as the last capture
  always_comb begin
    work_n = work;
    if (state == RUN && cyc >= 5'(SBOX_LAT))
      for (int l = 0; l < LANES; l++)
        work_n[4'(int'(cap) * LANES + l)] = sbox_data_i[8*l +: 8];
  end
  aes_row_perm u_perm (
    .s    (work_n),
    .mode (mode),
    .d    (perm)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cyc     <= '0;
      src     <= '0;
      work    <= '0;
      dec_q   <= 1'b0;
      byp_q   <= 1'b0;
      ready_o <= 1'b0;
      data_o  <= '0;
    end else begin
      state   <= state_n;
      work    <= work_n;
      ready_o <= last;
      if (last) data_o <= perm_flat;
      if (accept) begin
        src   <= din;
        dec_q <= decrypt_i;
        byp_q <= bypass_i;
        cyc   <= 5'd1;
      end else if (state == RUN) begin
        cyc <= last ? 5'd0 : cyc + 5'd1;
      end
    end
  end
endmodule

// File: tb/tb_subbytes_lanes.sv
// tb_subbytes_lanes: self-checking bench over several LANES/SBOX_LAT configurations with a GF(2^8) S-box model
module tb_subbytes_lanes;
  localparam int NC = 9;
  localparam int LN [NC] = '{1, 4, 2, 2, 4, 8, 8, 16, 16};
  localparam int LT [NC] = '{1, 1, 1, 3, 3, 1, 3, 1, 3};
  logic clk = 0;
  logic rst;
  logic start_a [NC], dec_a [NC], byp_a [NC], rdy_a [NC], busy_a [NC], sdec_a [NC];
  logic [127:0] din_a [NC], dout_a [NC], sbo_a [NC];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] r = 8'h01, q = x;
    for (int k = 1; k < 8; k++) begin
      q = gmul(q, q);
      r = gmul(r, q);
    end
    return r;
  endfunction
  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction
  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [7:0] v = ginv(x);
    return v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
  endfunction
  function automatic logic [7:0] isb(input logic [7:0] y);
    return ginv(rotl(y, 1) ^ rotl(y, 3) ^ rotl(y, 6) ^ 8'h05);
  endfunction
  function automatic logic [127:0] model(input logic [127:0] d, input logic dc, input logic by);
    logic [7:0] s [16];
    logic [127:0] r = 0;
    int j;
    for (int k = 0; k < 16; k++) s[k] = dc ? isb(d[127-8*k -: 8]) : sb(d[127-8*k -: 8]);
    for (int i = 0; i < 16; i++) begin
      j = by ? i : dc ? ((i - 4 * (i % 4)) % 16 + 16) % 16 : (i + 4 * (i % 4)) % 16;
      r[127-8*i -: 8] = s[j];
    end
    return r;
  endfunction
  for (genvar g = 0; g < NC; g++) begin : g_cfg
    localparam int L = LN[g];
    localparam int LAT = LT[g];
    logic [8*L-1:0] so, si;
    logic [8*L-1:0] pipe [LAT];
    logic rdy, busy, sd;
    logic [127:0] dout;
    always @(posedge clk) begin
      for (int l = 0; l < L; l++) pipe[0][8*l +: 8] <= sd ? isb(so[8*l +: 8]) : sb(so[8*l +: 8]);
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign si = pipe[LAT-1];
    assign rdy_a[g] = rdy;
    assign busy_a[g] = busy;
    assign sdec_a[g] = sd;
    assign dout_a[g] = dout;
    assign sbo_a[g] = 128'(so);
    subbytes_lanes #(.LANES(L), .SBOX_LAT(LAT)) dut (
      .clk(clk), .reset(rst), .start_i(start_a[g]), .decrypt_i(dec_a[g]), .bypass_i(byp_a[g]),
      .data_i(din_a[g]), .ready_o(rdy), .busy_o(busy), .data_o(dout),
      .sbox_data_o(so), .sbox_data_i(si), .sbox_decrypt_o(sd)
    );
  end
  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask
  task automatic run_op(input int g, input logic [127:0] d, input logic dc, input logic by, input bit scr,
                        output logic [127:0] got, output int lat, output bit bok);
    @(negedge clk);
    start_a[g] = 1; din_a[g] = d; dec_a[g] = dc; byp_a[g] = by;
    lat = -1; bok = 1; got = 'x;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(negedge clk);
      if (rdy_a[g]) begin
        lat = n;
        got = dout_a[g];
      end else begin
        if (!busy_a[g] || sdec_a[g] !== dc) bok = 0;
        start_a[g] = scr ? 1'($urandom) : 1'b0;
        if (scr) begin
          din_a[g] = {$urandom, $urandom, $urandom, $urandom};
          dec_a[g] = 1'($urandom);
        end
      end
    end
    start_a[g] = 0;
  endtask
  typedef struct {
    logic [127:0] d;
    logic dc, by;
    logic [127:0] exp;
  } tv_t;
  initial begin
    tv_t tbl [7];
    logic [127:0] got, prev, v [3];
    int lat, k, last, gap;
    bit bok, seen, bad;
    rst = 1;
    for (int g = 0; g < NC; g++) begin
      start_a[g] = 0; dec_a[g] = 0; byp_a[g] = 0; din_a[g] = '0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < NC; g++) begin
      chk($sformatf("reset_ready[%0d]", g), 128'(rdy_a[g]), 0);
      chk($sformatf("reset_busy[%0d]", g), 128'(busy_a[g]), 0);
      chk($sformatf("reset_data[%0d]", g), dout_a[g], 0);
      chk($sformatf("reset_sbox[%0d]", g), sbo_a[g], 0);
      dec_a[g] = 1;
      #1 chk($sformatf("idle_sdec[%0d]", g), 128'(sdec_a[g]), 1);
      dec_a[g] = 0;
    end
    rst = 0;
    tbl[0] = '{128'h193de3bea0f4e22b9ac68d2ae9f84808, 0, 0, 128'hd4bf5d30e0b452aeb84111f11e2798e5};
    tbl[1] = '{128'h193de3bea0f4e22b9ac68d2ae9f84808, 0, 1, 128'hd42711aee0bf98f1b8b45de51e415230};
    tbl[2] = '{128'hd4bf5d30e0b452aeb84111f11e2798e5, 1, 0, 128'h193de3bea0f4e22b9ac68d2ae9f84808};
    for (int t = 3; t < 7; t++) begin
      tbl[t].d = {$urandom, $urandom, $urandom, $urandom};
      tbl[t].dc = 1'(t % 2);
      tbl[t].by = 1'(t == 6);
      tbl[t].exp = model(tbl[t].d, tbl[t].dc, tbl[t].by);
    end
    for (int g = 0; g < NC; g++)
      for (int t = 0; t < 7; t++) begin
        run_op(g, tbl[t].d, tbl[t].dc, tbl[t].by, 0, got, lat, bok);
        chk($sformatf("data[%0d,%0d]", g, t), got, tbl[t].exp);
        chk($sformatf("latency[%0d,%0d]", g, t), 128'(lat), 128'(16 / LN[g] + LT[g]));
        chk($sformatf("busy[%0d,%0d]", g, t), 128'(bok), 1);
      end
    for (int g = 0; g < NC; g += 6) begin
      v[0] = {$urandom, $urandom, $urandom, $urandom};
      run_op(g, v[0], 1, 0, 1, got, lat, bok);
      chk($sformatf("scramble_data[%0d]", g), got, model(v[0], 1, 0));
      chk($sformatf("scramble_sdec[%0d]", g), 128'(bok), 1);
      run_op(g, v[0], 1, 0, 0, got, lat, bok);
      chk($sformatf("stable_data[%0d]", g), got, model(v[0], 1, 0));
    end
    @(negedge clk);
    start_a[0] = 1; din_a[0] = tbl[0].d; dec_a[0] = 0; byp_a[0] = 0;
    seen = 0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      start_a[0] = 0;
      if (rdy_a[0]) seen = 1;
      if (n == 5) rst = 1;
      if (n == 6) begin
        rst = 0;
        chk("abort_data", dout_a[0], 0);
        chk("abort_busy", 128'(busy_a[0]), 0);
        chk("abort_sbox", sbo_a[0], 0);
      end
    end
    run_op(0, tbl[0].d, 0, 0, 0, got, lat, bok);
    chk("abort_ready", 128'(seen), 0);
    chk("after_abort_data", got, tbl[0].exp);
    chk("after_abort_latency", 128'(lat), 17);
    @(negedge clk) rst = 1;
    @(negedge clk) rst = 0;
    for (int i = 0; i < 3; i++) v[i] = {$urandom, $urandom, $urandom, $urandom};
    start_a[1] = 1; din_a[1] = v[0]; dec_a[1] = 0; byp_a[1] = 0;
    k = 0; last = 0; prev = 0; bad = 0;
    for (int n = 1; n <= 40 && k < 3; n++) begin
      @(negedge clk);
      if (rdy_a[1]) begin
        gap = n - last;
        chk($sformatf("b2b_data[%0d]", k), dout_a[1], model(v[k], 0, 0));
        chk($sformatf("b2b_gap[%0d]", k), 128'(gap), 5);
        prev = model(v[k], 0, 0);
        last = n;
        k++;
        if (k < 3) din_a[1] = v[k];
        else start_a[1] = 0;
      end else begin
        if (dout_a[1] !== prev) bad = 1;
        din_a[1] = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    start_a[1] = 0;
    chk("b2b_count", 128'(k), 3);
    chk("b2b_hold", 128'(bad), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
